// File: rtl/aes_key_sched_pkg.sv
// Shared constants, FSM encoding and word helpers for the AES-128 key schedule.
package aes_key_sched_pkg;

  localparam int RND_SIZE = 128;
  localparam int WRD_SIZE = 32;
  localparam int NUM_RND  = 10;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RND);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WRD_SIZE-1:0] rot_word(input logic [WRD_SIZE-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-in handshake, round-key stream and bank read port of aes_key_sched.
interface aes_key_sched_if;
  import aes_key_sched_pkg::*;

  logic [RND_SIZE-1:0] i_key;
  logic                i_key_vld;
  logic                o_key_rdy;
  logic [RND_SIZE-1:0] o_rk;
  logic                o_rk_vld;
  logic [IDX_W-1:0]    o_rk_idx;
  logic                o_lst_rnd;
  logic                o_sched_done;
  logic                i_rd_en;
  logic [IDX_W-1:0]    i_rd_idx;
  logic [RND_SIZE-1:0] o_rd_key;
  logic                o_rd_vld;

  modport master (
    output i_key, i_key_vld, i_rd_en, i_rd_idx,
    input  o_key_rdy, o_rk, o_rk_vld, o_rk_idx, o_lst_rnd, o_sched_done,
    input  o_rd_key, o_rd_vld
  );

  modport slave (
    input  i_key, i_key_vld, i_rd_en, i_rd_idx,
    output o_key_rdy, o_rk, o_rk_vld, o_rk_idx, o_lst_rnd, o_sched_done,
    output o_rd_key, o_rd_vld
  );

endinterface

// File: rtl/aes_sbox.sv
// Word-wide AES S-box: four parallel byte substitutions from a constant table.
module aes_sbox (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Byte 0x00 sits in the top 8 bits, 0xff in the bottom 8 bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] off;
    off = {~b, 3'b000};
    return SBOX_TBL[off +: 8];
  endfunction

  assign o_word = {sub_byte(i_word[31:24]), sub_byte(i_word[23:16]),
                   sub_byte(i_word[15:8]),  sub_byte(i_word[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion, one round key per clock.
// Define AES_KSCHED_STORE_EN to keep all round keys in a readable local bank.
module aes_key_sched
  import aes_key_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  aes_key_sched_if.slave bus
);

  state_e              state_q, state_d;
  logic                load;
  logic                last;
  logic                rdy_q;
  logic                done_q;
  logic                lst_q;
  logic [RND_SIZE-1:0] w_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_nxt;
  logic [7:0]          rcon_q;

  logic [WRD_SIZE-1:0] rot_w, sub_w, t_w;
  logic [WRD_SIZE-1:0] w0n, w1n, w2n, w3n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_key_vld && rdy_q) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One S-box serves every iteration; SubWord only ever needs w3.
  assign rot_w = rot_word(w_q[WRD_SIZE-1:0]);

  aes_sbox u_sbox (
    .i_word (rot_w),
    .o_word (sub_w)
  );

  assign t_w     = sub_w ^ {rcon_q, 24'h0};
  assign w0n     = w_q[127:96] ^ t_w;
  assign w1n     = w_q[95:64]  ^ w0n;
  assign w2n     = w_q[63:32]  ^ w1n;
  assign w3n     = w_q[31:0]   ^ w2n;
  assign idx_nxt = idx_q + 4'd1;

  // Stream registers are cleared on leaving EXPAND so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      lst_q  <= 1'b0;
      w_q    <= '0;
      idx_q  <= '0;
      rcon_q <= '0;
    end else begin
      rdy_q <= (state_d == IDLE);
      if (load) begin
        w_q    <= bus.i_key;
        idx_q  <= '0;
        rcon_q <= 8'h01;
        lst_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (last) begin
        w_q    <= '0;
        idx_q  <= '0;
        rcon_q <= '0;
        lst_q  <= 1'b0;
        done_q <= 1'b1;
      end else if (state_q == EXPAND) begin
        w_q    <= {w0n, w1n, w2n, w3n};
        idx_q  <= idx_nxt;
        rcon_q <= xtime(rcon_q);
        lst_q  <= (idx_nxt == LAST_IDX);
      end
    end
  end

  assign bus.o_key_rdy    = rdy_q;
  assign bus.o_rk         = w_q;
  assign bus.o_rk_vld     = (state_q == EXPAND);
  assign bus.o_rk_idx     = idx_q;
  assign bus.o_lst_rnd    = lst_q;
  assign bus.o_sched_done = done_q;

`ifdef AES_KSCHED_STORE_EN
  logic [RND_SIZE-1:0] bank [NUM_RND+1];
  logic [RND_SIZE-1:0] rd_key_q;
  logic                rd_vld_q;

  // NOTE: the bank is reset because a never-written entry must read back as zero; that forces flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_RND; i++) bank[i] <= '0;
      rd_key_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (state_q == EXPAND) bank[idx_q] <= w_q;
      rd_vld_q <= bus.i_rd_en;
      if (bus.i_rd_en && (bus.i_rd_idx <= LAST_IDX)) rd_key_q <= bank[bus.i_rd_idx];
      else                                           rd_key_q <= '0;
    end
  end

  assign bus.o_rd_key = rd_key_q;
  assign bus.o_rd_vld = rd_vld_q;
`else
  wire unused_rd = ^{bus.i_rd_en, bus.i_rd_idx};

  assign bus.o_rd_key = '0;
  assign bus.o_rd_vld = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and all-zero key vectors, handshake, reset and read port.
module tb_aes_key_sched;
  import aes_key_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  aes_key_sched_if bus();

  aes_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  vec_t         vecs [14];
  logic [127:0] got  [11];
  int           passed = 0;
  int           total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic offer(input logic [127:0] key);
    int waited = 0;
    while (!bus.o_key_rdy && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("offer_rdy", 128'(bus.o_key_rdy), 128'd1);
    bus.i_key     = key;
    bus.i_key_vld = 1'b1;
    @(negedge clk);
    bus.i_key_vld = 1'b0;
  endtask

  // Entered in the cycle where round key 0 should be visible; c counts cycles from there.
  task automatic collect(input bit intrude, input bit chain, input logic [127:0] alt_key);
    int nvld = 0, first = -1, last = -1, lst_cnt = 0, lst_idx = -1, idle_bad = 0;
    int limit = chain ? 13 : 14;
    for (int i = 0; i < 11; i++) got[i] = '1;
    for (int c = 0; c < limit; c++) begin
      if (c < 12) begin
        if (bus.o_rk_vld) begin
          if (bus.o_rk_idx <= 4'd10) got[bus.o_rk_idx] = bus.o_rk;
          nvld++;
          if (first < 0) first = c;
          last = c;
        end else if (bus.o_rk != '0 || bus.o_rk_idx != '0 || bus.o_lst_rnd) begin
          idle_bad++;
        end
        if (bus.o_lst_rnd) begin
          lst_cnt++;
          lst_idx = int'(bus.o_rk_idx);
        end
      end
      if (intrude && c == 3) begin
        bus.i_key     = alt_key;
        bus.i_key_vld = 1'b1;
      end
      if (intrude && c == 4) bus.i_key_vld = 1'b0;
      if (chain && c == 10) begin
        bus.i_key     = alt_key;
        bus.i_key_vld = 1'b1;
      end
      if (chain && c == 11) begin
        check("rdy_at_t12",  128'(bus.o_key_rdy),    128'd1);
        check("done_at_t12", 128'(bus.o_sched_done), 128'd1);
        check("no_early_accept", 128'(bus.o_rk_vld), 128'd0);
      end
      if (chain && c == 12) begin
        check("done_drop_t13", 128'(bus.o_sched_done), 128'd0);
        check("chain_vld",     128'(bus.o_rk_vld),     128'd1);
        check("chain_idx0",    128'(bus.o_rk_idx),     128'd0);
        check("chain_rk0",     bus.o_rk,               alt_key);
        bus.i_key_vld = 1'b0;
      end
      if (c < limit - 1) @(negedge clk);
    end
    check("vld_count",    128'(nvld),          128'd11);
    check("vld_first",    128'(first),         128'd0);
    check("vld_span",     128'(last - first + 1), 128'd11);
    check("lst_count",    128'(lst_cnt),       128'd1);
    check("lst_idx",      128'(lst_idx),       128'd10);
    check("idle_outputs", 128'(idle_bad),      128'd0);
    if (!chain) begin
      check("done_level", 128'(bus.o_sched_done), 128'd1);
      check("rdy_back",   128'(bus.o_key_rdy),    128'd1);
    end
  endtask

  task automatic compare_table(input logic [127:0] key);
    for (int i = 0; i < 14; i++)
      if (vecs[i].key == key)
        check($sformatf("rk_%0h_%0d", key[127:112], vecs[i].idx), got[vecs[i].idx], vecs[i].rk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{FIPS_KEY, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[11] = '{ZERO_KEY, 0,  128'h0};
    vecs[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vecs[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n         = 1'b0;
    bus.i_key     = '0;
    bus.i_key_vld = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_rd_idx  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rk_vld", 128'(bus.o_rk_vld),     128'd0);
    check("rst_rk",     bus.o_rk,               128'd0);
    check("rst_idx",    128'(bus.o_rk_idx),     128'd0);
    check("rst_lst",    128'(bus.o_lst_rnd),    128'd0);
    check("rst_done",   128'(bus.o_sched_done), 128'd0);
    check("rst_rd_vld", 128'(bus.o_rd_vld),     128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 128'(bus.o_key_rdy), 128'd1);

    // FIPS-197 key, full stream
    offer(FIPS_KEY);
    collect(1'b0, 1'b0, '0);
    compare_table(FIPS_KEY);

`ifdef AES_KSCHED_STORE_EN
    bus.i_rd_en  = 1'b1;
    bus.i_rd_idx = 4'd10;
    @(negedge clk);
    check("rd10_vld", 128'(bus.o_rd_vld), 128'd1);
    check("rd10_key", bus.o_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    bus.i_rd_idx = 4'd12;
    @(negedge clk);
    check("rd12_vld", 128'(bus.o_rd_vld), 128'd1);
    check("rd12_key", bus.o_rd_key, 128'd0);
    bus.i_rd_idx = 4'd0;
    @(negedge clk);
    check("rd0_key", bus.o_rd_key, FIPS_KEY);
    bus.i_rd_en = 1'b0;
    @(negedge clk);
    check("rd_idle_vld", 128'(bus.o_rd_vld), 128'd0);
`else
    begin
      int rd_hi = 0, rd_nz = 0;
      for (int c = 0; c < 10; c++) begin
        bus.i_rd_en  = (c % 3 != 0);
        bus.i_rd_idx = 4'(c + 3);
        @(negedge clk);
        if (bus.o_rd_vld) rd_hi++;
        if (bus.o_rd_key != '0) rd_nz++;
      end
      bus.i_rd_en = 1'b0;
      check("rd_vld_off", 128'(rd_hi), 128'd0);
      check("rd_key_off", 128'(rd_nz), 128'd0);
    end
`endif

    // All-zero key with an ignored mid-stream offer, then a back-to-back FIPS key at T+12
    offer(ZERO_KEY);
    collect(1'b1, 1'b1, FIPS_KEY);
    compare_table(ZERO_KEY);
    collect(1'b0, 1'b0, '0);
    compare_table(FIPS_KEY);

    // Reset during round key 5, then a fresh expansion
    offer(FIPS_KEY);
    repeat (5) @(negedge clk);
    check("pre_rst_idx", 128'(bus.o_rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  128'(bus.o_rk_vld),     128'd0);
    check("mid_rst_rk",   bus.o_rk,               128'd0);
    check("mid_rst_idx",  128'(bus.o_rk_idx),     128'd0);
    check("mid_rst_lst",  128'(bus.o_lst_rnd),    128'd0);
    check("mid_rst_done", 128'(bus.o_sched_done), 128'd0);
    check("mid_rst_rdkey", bus.o_rd_key,          128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 128'(bus.o_key_rdy), 128'd1);
    check("post_rst_vld", 128'(bus.o_rk_vld),  128'd0);
`ifdef AES_KSCHED_STORE_EN
    bus.i_rd_en  = 1'b1;
    bus.i_rd_idx = 4'd3;
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    check("bank_cleared", bus.o_rd_key, 128'd0);
`endif
    offer(ZERO_KEY);
    collect(1'b0, 1'b0, '0);
    compare_table(ZERO_KEY);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
